// File: rtl/bnadd_share_arb_if.sv
// Handshake and data bundle between the accumulator requesters, the BN-ADD engine
// and the shared-engine arbiter. The master modport is the arbiter's view.
interface bnadd_share_arb_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]      req_v;
    logic [NUM_REQ*1024-1:0] req_data;
    logic [NUM_REQ-1:0]      req_rdy;
    logic [1023:0]           eng_data;
    logic                    eng_v;
    logic [1023:0]           eng_res;
    logic                    eng_res_v;
    logic [1023:0]           res_data;
    logic                    res_v;
    logic [ID_W-1:0]         res_id;
    logic                    busy;
    logic [15:0]             jobs_done;

    modport master (
        input  req_v, req_data, eng_res, eng_res_v,
        output req_rdy, eng_data, eng_v, res_data, res_v, res_id, busy, jobs_done
    );

    modport slave (
        output req_v, req_data, eng_res, eng_res_v,
        input  req_rdy, eng_data, eng_v, res_data, res_v, res_id, busy, jobs_done
    );
endinterface

// File: rtl/bnadd_share_arb.sv
// Round-robin arbiter sharing one 1024-bit BN-ADD engine among NUM_REQ producers,
// one job in flight. Optional WAIT watchdog enabled by macro BNADD_ARB_TIMEOUT_EN.
module bnadd_share_arb #(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst,
    bnadd_share_arb_if.master bus
`ifdef BNADD_ARB_TIMEOUT_EN
    ,
    output logic timeout_err
`endif
);
    localparam int DW = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8 || ID_W < $clog2(NUM_REQ) || TIMEOUT_CYC < 1) begin : g_bad_cfg
            $error("bnadd_share_arb: unsupported parameter combination");
        end
    endgenerate

    state_t             state_reg, state_next;
    logic [ID_W-1:0]    rr_ptr_reg;
    logic [ID_W-1:0]    id_reg;
    logic [ID_W-1:0]    res_id_reg;
    logic [DW-1:0]      job_reg;
    logic [DW-1:0]      res_data_reg;
    logic [15:0]        jobs_done_reg;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    win_idx;
    logic [DW-1:0]      win_data;
    logic [DW-1:0]      req_slice [NUM_REQ];
    logic               xfer;
    logic               res_take;
    logic               timed_out;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign req_slice[gi] = bus.req_data[gi*DW +: DW];
        end
    endgenerate

    // Search upward from rr_ptr+1 with wrap; the first requester hit wins.
    always_comb begin
        logic found;
        found    = 1'b0;
        grant    = '0;
        win_idx  = '0;
        win_data = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && bus.req_v[i] && (i == (int'(rr_ptr_reg) + k) % NUM_REQ)) begin
                    found    = 1'b1;
                    grant[i] = 1'b1;
                    win_idx  = ID_W'(i);
                    win_data = req_slice[i];
                end
            end
        end
    end

`ifdef BNADD_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] wait_cnt_reg;
    logic          timeout_err_reg;
`endif

    always_comb begin
        state_next = state_reg;
        xfer       = 1'b0;
        res_take   = 1'b0;
        timed_out  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|grant) begin
                    xfer       = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (bus.eng_res_v) begin
                    res_take   = 1'b1;
                    state_next = DONE;
                end
`ifdef BNADD_ARB_TIMEOUT_EN
                else if (wait_cnt_reg == CW'(TIMEOUT_CYC - 1)) begin
                    timed_out  = 1'b1;
                    state_next = IDLE;
                end
`endif
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= ID_W'(NUM_REQ - 1);
            id_reg        <= '0;
            job_reg       <= '0;
            res_data_reg  <= '0;
            res_id_reg    <= '0;
            jobs_done_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (xfer) begin
                job_reg    <= win_data;
                id_reg     <= win_idx;
                rr_ptr_reg <= win_idx;
            end
            if (res_take) begin
                res_data_reg <= bus.eng_res;
                res_id_reg   <= id_reg;
            end
            if (state_reg == DONE && jobs_done_reg != 16'hFFFF) begin
                jobs_done_reg <= jobs_done_reg + 16'd1;
            end
        end
    end

`ifdef BNADD_ARB_TIMEOUT_EN
    // Counter restarts during ISSUE so it reads zero in the first WAIT cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt_reg    <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            if (state_reg == ISSUE) begin
                wait_cnt_reg <= '0;
            end else if (state_reg == WAIT) begin
                wait_cnt_reg <= wait_cnt_reg + CW'(1);
            end
            if (timed_out) begin
                timeout_err_reg <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_err_reg;
`endif

    // Grant is withheld while reset is asserted so nothing looks accepted.
    assign bus.req_rdy   = (state_reg == IDLE && rst) ? grant : '0;
    assign bus.eng_v     = (state_reg == ISSUE);
    assign bus.eng_data  = job_reg;
    assign bus.res_v     = (state_reg == DONE);
    assign bus.res_data  = res_data_reg;
    assign bus.res_id    = res_id_reg;
    assign bus.busy      = (state_reg != IDLE);
    assign bus.jobs_done = jobs_done_reg;

endmodule

// File: tb/tb_bnadd_share_arb.sv
// Self-checking bench for bnadd_share_arb: vector table, hand-written corner
// sequences and randomized jobs against a round-robin reference model.
module tb_bnadd_share_arb;
    localparam int N  = 4;
    localparam int DW = 1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bnadd_share_arb_if #(.NUM_REQ(N), .ID_W(2)) bus ();

`ifdef BNADD_ARB_TIMEOUT_EN
    logic timeout_err;
`endif

    bnadd_share_arb #(.NUM_REQ(N), .ID_W(2), .TIMEOUT_CYC(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef BNADD_ARB_TIMEOUT_EN
        ,
        .timeout_err(timeout_err)
`endif
    );

    typedef struct {
        logic [N-1:0] mask;
        int           exp_id;
        int           lat;
    } vec_t;

    vec_t          vecs [12];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            exp_done = 0;
    int            model_ptr = N - 1;
    logic [DW-1:0] last_res = '0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (low 64 bits)", name, act[63:0], exp[63:0]);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] r;
        for (int w = 0; w < DW/32; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference: the winner is the nearest requester strictly after ptr, cyclically.
    function automatic int predict(input logic [N-1:0] mask, input int ptr);
        int idx;
        for (int step = 1; step <= N; step++) begin
            idx = (ptr + step) % N;
            if (mask[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    // Called at a negedge in IDLE; returns at the negedge of the ISSUE cycle.
    task automatic start_job(input logic [N-1:0] mask, input int exp_id, input bit spur,
                             input bit fixed, output logic [DW-1:0] job);
        logic [DW-1:0] pay;
        job = '0;
        for (int i = 0; i < N; i++) begin
            pay = (fixed && i == exp_id) ? DW'(1) : rand_word();
            bus.req_data[i*DW +: DW] = pay;
            if (i == exp_id) job = pay;
        end
        bus.req_v = mask;
        #1;
        check("grant", DW'(bus.req_rdy), DW'(1 << exp_id));
        check("idle_busy", DW'(bus.busy), DW'(0));
        @(posedge clk);
        #1;
        bus.req_v = '0;
        @(negedge clk);
        check("eng_v", DW'(bus.eng_v), DW'(1));
        check("eng_data", bus.eng_data, job);
        check("req_rdy_busy", DW'(bus.req_rdy), DW'(0));
        if (spur) begin
            bus.eng_res_v = 1'b1;
            bus.eng_res   = ~job;
        end
        model_ptr = exp_id;
    endtask

    task automatic finish_job(input int lat, input logic [DW-1:0] job, input int exp_id);
        for (int c = 0; c < lat; c++) begin
            @(negedge clk);
            bus.eng_res_v = 1'b0;
            check("res_v_early", DW'(bus.res_v), DW'(0));
            check("res_hold", bus.res_data, last_res);
            if (c == lat - 1) begin
                bus.eng_res_v = 1'b1;
                bus.eng_res   = job + DW'(1);
            end
        end
        @(negedge clk);
        bus.eng_res_v = 1'b0;
        last_res = job + DW'(1);
        exp_done++;
        check("res_v", DW'(bus.res_v), DW'(1));
        check("res_data", bus.res_data, last_res);
        check("res_id", DW'(bus.res_id), DW'(exp_id));
        @(negedge clk);
        check("res_v_pulse", DW'(bus.res_v), DW'(0));
        check("jobs_done", DW'(bus.jobs_done), DW'(exp_done));
        check("busy_after", DW'(bus.busy), DW'(0));
    endtask

    initial begin
        logic [DW-1:0] job;
        logic [N-1:0]  m;
        int            e;

        vecs[0]  = '{4'b0001, 0, 6};
        vecs[1]  = '{4'b1111, 1, 2};
        vecs[2]  = '{4'b1111, 2, 1};
        vecs[3]  = '{4'b1111, 3, 4};
        vecs[4]  = '{4'b1111, 0, 3};
        vecs[5]  = '{4'b1010, 1, 2};
        vecs[6]  = '{4'b1010, 3, 5};
        vecs[7]  = '{4'b1010, 1, 1};
        vecs[8]  = '{4'b0100, 2, 2};
        vecs[9]  = '{4'b0011, 0, 3};
        vecs[10] = '{4'b1001, 3, 2};
        vecs[11] = '{4'b1000, 3, 1};

        rst           = 1'b0;
        bus.req_v     = '0;
        bus.req_data  = '0;
        bus.eng_res   = '0;
        bus.eng_res_v = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_rdy", DW'(bus.req_rdy), DW'(0));
        check("rst_eng_v", DW'(bus.eng_v), DW'(0));
        check("rst_res_v", DW'(bus.res_v), DW'(0));
        check("rst_busy", DW'(bus.busy), DW'(0));
        check("rst_eng_data", bus.eng_data, DW'(0));
        check("rst_res_data", bus.res_data, DW'(0));
        check("rst_res_id", DW'(bus.res_id), DW'(0));
        check("rst_jobs_done", DW'(bus.jobs_done), DW'(0));
        rst = 1'b1;
        @(negedge clk);

        // Single job with payload 1; the first vector entry carries it.
        start_job(vecs[0].mask, vecs[0].exp_id, 1'b0, 1'b1, job);
        finish_job(vecs[0].lat, job, vecs[0].exp_id);
        check("single_res_is_2", bus.res_data, DW'(2));

        for (int v = 1; v < 12; v++) begin
            start_job(vecs[v].mask, vecs[v].exp_id, 1'b0, 1'b0, job);
            finish_job(vecs[v].lat, job, vecs[v].exp_id);
        end

        // Engine valid in IDLE must be ignored.
        bus.eng_res_v = 1'b1;
        bus.eng_res   = rand_word();
        @(negedge clk);
        bus.eng_res_v = 1'b0;
        check("spur_idle_res_v", DW'(bus.res_v), DW'(0));
        check("spur_idle_res_data", bus.res_data, last_res);
        check("spur_idle_busy", DW'(bus.busy), DW'(0));
        check("spur_idle_done", DW'(bus.jobs_done), DW'(exp_done));

        // Engine valid during ISSUE is ignored; the real one in WAIT completes.
        e = predict(4'b0110, model_ptr);
        start_job(4'b0110, e, 1'b1, 1'b0, job);
        finish_job(3, job, e);

        // Arbitration follows req_v changes inside one IDLE cycle.
        @(negedge clk);
        bus.req_v = 4'b0100;
        #1;
        check("reeval_first", DW'(bus.req_rdy), DW'(4'b0100));
        bus.req_v = 4'b0001;
        #1;
        check("reeval_second", DW'(bus.req_rdy), DW'(4'b0001));
        start_job(4'b0001, 0, 1'b0, 1'b0, job);
        finish_job(2, job, 0);

        for (int r = 0; r < 20; r++) begin
            m = N'($urandom_range(1, 15));
            e = predict(m, model_ptr);
            start_job(m, e, 1'($urandom_range(0, 1)), 1'b0, job);
            finish_job(int'($urandom_range(1, 10)), job, e);
        end

        // Reset while waiting on the engine drops the job.
        e = predict(4'b0010, model_ptr);
        start_job(4'b0010, e, 1'b0, 1'b0, job);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst       = 1'b1;
        exp_done  = 0;
        last_res  = '0;
        model_ptr = N - 1;
        check("midrst_busy", DW'(bus.busy), DW'(0));
        check("midrst_done", DW'(bus.jobs_done), DW'(0));
        check("midrst_eng_data", bus.eng_data, DW'(0));
        bus.eng_res_v = 1'b1;
        bus.eng_res   = job + DW'(1);
        @(negedge clk);
        bus.eng_res_v = 1'b0;
        check("midrst_res_v", DW'(bus.res_v), DW'(0));
        @(negedge clk);
        check("midrst_res_v2", DW'(bus.res_v), DW'(0));
        check("midrst_res_data", bus.res_data, DW'(0));
        start_job(4'b1111, 0, 1'b0, 1'b0, job);
        finish_job(4, job, 0);

`ifdef BNADD_ARB_TIMEOUT_EN
        check("to_err_clear", DW'(timeout_err), DW'(0));
        e = predict(4'b1000, model_ptr);
        start_job(4'b1000, e, 1'b0, 1'b0, job);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("to_wait_busy", DW'(bus.busy), DW'(1));
            check("to_wait_res_v", DW'(bus.res_v), DW'(0));
        end
        @(negedge clk);
        check("to_idle", DW'(bus.busy), DW'(0));
        check("to_err_set", DW'(timeout_err), DW'(1));
        check("to_done", DW'(bus.jobs_done), DW'(exp_done));
        e = predict(4'b0001, model_ptr);
        start_job(4'b0001, e, 1'b0, 1'b0, job);
        finish_job(3, job, e);
        check("to_err_sticky", DW'(timeout_err), DW'(1));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
